// File: rtl/migu_mem_pkg.sv
// rtl/migu_mem_pkg.sv - shared requester indices, widths and types for the MigU SRAM arbiter
package migu_mem_pkg;

    localparam int NREQ      = 3;
    localparam int WORD_BITS = 32;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_DBG = 2'd0;
    localparam req_idx_t REQ_LS  = 2'd1;
    localparam req_idx_t REQ_IF  = 2'd2;

endpackage

// File: rtl/migu_sram_arbiter_if.sv
// rtl/migu_sram_arbiter_if.sv - requester-side request/response bundle of the MigU SRAM arbiter
interface migu_sram_arbiter_if
    import migu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 18
);

    logic [NREQ-1:0]                 req_valid;
    logic [NREQ-1:0]                 req_ready;
    logic [NREQ-1:0]                 req_we;
    logic [NREQ-1:0][ADDR_WIDTH-3:0] req_addr;
    logic [NREQ-1:0][WORD_BITS-1:0]  req_wdata;
    logic [NREQ-1:0][3:0]            req_be;
    logic                            if_flush;
    logic [NREQ-1:0]                 rsp_valid;
    logic [WORD_BITS-1:0]            rsp_rdata;

    // Requesters (pipeline, debug) drive requests and consume responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, if_flush,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // The arbiter consumes requests and produces grants and responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, if_flush,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/migu_prio_pick.sv
// rtl/migu_prio_pick.sv - fixed-priority one-hot picker, DBG first, promote swaps LS/IF
module migu_prio_pick
    import migu_mem_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  logic            promote,
    output logic [NREQ-1:0] grant,
    output req_idx_t        idx
);

    // DBG always wins; promote lets a starved IF jump ahead of LS.
    always_comb begin
        grant = '0;
        idx   = REQ_DBG;
        if (valid[REQ_DBG]) begin
            grant[REQ_DBG] = 1'b1;
            idx            = REQ_DBG;
        end else if (promote && valid[REQ_IF]) begin
            grant[REQ_IF] = 1'b1;
            idx           = REQ_IF;
        end else if (valid[REQ_LS]) begin
            grant[REQ_LS] = 1'b1;
            idx           = REQ_LS;
        end else if (valid[REQ_IF]) begin
            grant[REQ_IF] = 1'b1;
            idx           = REQ_IF;
        end
    end

endmodule

// File: rtl/migu_sram_arbiter.sv
// rtl/migu_sram_arbiter.sv - single-port SRAM arbiter (DBG/LS/IF); optional IF starvation guard via MIGU_SRAM_ARB_STARVE_EN
module migu_sram_arbiter
    import migu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 18,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    migu_sram_arbiter_if.slave    bus,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [WORD_BITS-1:0]  mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [WORD_BITS-1:0]  mem_rdata
);

    logic [NREQ-1:0] live_valid;
    logic [NREQ-1:0] grant;
    req_idx_t        gnt_idx;
    logic            promote;

    logic            rsp_pend;
    req_idx_t        owner;
    logic            rsp_is_rd;

    // Grants are suppressed while reset is held, whatever the requesters do.
    assign live_valid = bus.req_valid & {NREQ{rstn}};

    migu_prio_pick u_pick (
        .valid   (live_valid),
        .promote (promote),
        .grant   (grant),
        .idx     (gnt_idx)
    );

    assign bus.req_ready = grant;
    assign mem_en        = |grant;

`ifdef MIGU_SRAM_ARB_STARVE_EN
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;

    assign promote = (starve_cnt == STARVE_MAX);

    // Count consecutive cycles IF waits; saturate so promote holds until IF actually wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= 8'd0;
        end else if (!bus.req_valid[REQ_IF] || grant[REQ_IF]) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    logic unused_starve_cfg;

    assign promote           = 1'b0;
    assign unused_starve_cfg = (STARVE_LIMIT != 0);
`endif

    // Route the winning request onto the SRAM port; fields are don't-care when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = bus.req_addr[REQ_DBG];
        mem_wdata = bus.req_wdata[REQ_DBG];
        mem_be    = bus.req_be[REQ_DBG];
        case (gnt_idx)
            REQ_LS: begin
                mem_we    = bus.req_we[REQ_LS];
                mem_addr  = bus.req_addr[REQ_LS];
                mem_wdata = bus.req_wdata[REQ_LS];
                mem_be    = bus.req_be[REQ_LS];
            end
            REQ_IF: begin
                mem_we    = bus.req_we[REQ_IF];
                mem_addr  = bus.req_addr[REQ_IF];
                mem_wdata = bus.req_wdata[REQ_IF];
                mem_be    = bus.req_be[REQ_IF];
            end
            default: begin
                mem_we    = bus.req_we[REQ_DBG];
                mem_addr  = bus.req_addr[REQ_DBG];
                mem_wdata = bus.req_wdata[REQ_DBG];
                mem_be    = bus.req_be[REQ_DBG];
            end
        endcase
        mem_we = mem_we & mem_en;
    end

    // Remember who was served this cycle so the SRAM's late data goes back to them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_pend  <= 1'b0;
            owner     <= REQ_DBG;
            rsp_is_rd <= 1'b0;
        end else begin
            rsp_pend  <= mem_en;
            owner     <= gnt_idx;
            rsp_is_rd <= mem_en & ~mem_we;
        end
    end

    // One-hot response strobe; a fetch redirect kills the IF response due now.
    always_comb begin
        bus.rsp_valid = '0;
        if (rsp_pend) begin
            case (owner)
                REQ_LS:  bus.rsp_valid[REQ_LS]  = 1'b1;
                REQ_IF:  bus.rsp_valid[REQ_IF]  = ~bus.if_flush;
                default: bus.rsp_valid[REQ_DBG] = 1'b1;
            endcase
        end
        bus.rsp_rdata = (rsp_is_rd && |bus.rsp_valid) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_migu_sram_arbiter.sv
// tb/tb_migu_sram_arbiter.sv - self-checking bench for migu_sram_arbiter with SRAM fixture and reference model
module tb_migu_sram_arbiter;
    import migu_mem_pkg::*;

    localparam int AW  = 18;
    localparam int LIM = 4;
`ifdef MIGU_SRAM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    migu_sram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    logic          mem_en;
    logic          mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata = 32'd0;

    migu_sram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    // SRAM macro fixture: synchronous, byte-enabled writes, one-cycle read.
    logic [31:0] sram    [0:65535];
    logic [31:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          m_pend  = 0;
    int          m_owner = 0;
    bit          m_rd    = 0;
    logic [31:0] m_data  = 0;
    int          starve  = 0;
    logic [2:0]  exp_g;
    logic [2:0]  dut_g;
    int          if_wins;
    logic [31:0] old_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance the model.
    task automatic step();
        logic [2:0]  v;
        logic [2:0]  ev;
        logic [31:0] ed;
        int          k;
        bit          np;
        bit          nrd;
        logic [31:0] nd;
        logic [15:0] a;
        @(negedge clk);
        if (!rstn) begin
            m_pend = 0;
            starve = 0;
        end
        v     = bus.req_valid;
        exp_g = 3'b000;
        k     = 0;
        if (rstn) begin
            if (v[0])                                     begin exp_g = 3'b001; k = 0; end
            else if (STARVE_ON && v[2] && starve >= LIM)  begin exp_g = 3'b100; k = 2; end
            else if (v[1])                                begin exp_g = 3'b010; k = 1; end
            else if (v[2])                                begin exp_g = 3'b100; k = 2; end
        end
        dut_g = bus.req_ready;
        chk("req_ready", {29'd0, bus.req_ready}, {29'd0, exp_g});
        chk("mem_en", {31'd0, mem_en}, {31'd0, exp_g != 3'b000});
        if (v[2]) chk("if_write_illegal", {31'd0, bus.req_we[2]}, 32'd0);
        np  = 0;
        nrd = 0;
        nd  = 0;
        if (exp_g != 3'b000) begin
            a = bus.req_addr[k];
            chk("mem_we", {31'd0, mem_we}, {31'd0, bus.req_we[k]});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, a});
            if (bus.req_we[k]) begin
                chk("mem_wdata", mem_wdata, bus.req_wdata[k]);
                chk("mem_be", {28'd0, mem_be}, {28'd0, bus.req_be[k]});
                for (int b = 0; b < 4; b++)
                    if (bus.req_be[k][b]) ref_mem[a][8*b +: 8] = bus.req_wdata[k][8*b +: 8];
            end else begin
                nrd = 1;
                nd  = ref_mem[a];
            end
            np = 1;
        end else begin
            chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
        end
        ev = 3'b000;
        ed = 32'd0;
        if (m_pend && !(m_owner == 2 && bus.if_flush)) ev = 3'(1 << m_owner);
        if (ev != 3'b000 && m_rd) ed = m_data;
        chk("rsp_valid", {29'd0, bus.rsp_valid}, {29'd0, ev});
        chk("rsp_rdata", bus.rsp_rdata, ed);
        if (rstn) begin
            if (v[2] && !exp_g[2]) starve = (starve + 1 > LIM) ? LIM : starve + 1;
            else                   starve = 0;
        end
        @(posedge clk);
        #1;
        m_pend  = np && rstn;
        m_owner = k;
        m_rd    = nrd;
        m_data  = nd;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input logic [15:0] addr,
                           input logic [31:0] d, input logic [3:0] be);
        bus.req_valid[i] = v;
        bus.req_we[i]    = we;
        bus.req_addr[i]  = addr;
        bus.req_wdata[i] = d;
        bus.req_be[i]    = be;
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) set_req(i, 0, 0, 16'd0, 32'd0, 4'd0);
        bus.if_flush = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[16'h0010]    = 32'hDEADBEEF;
        ref_mem[16'h0010] = 32'hDEADBEEF;
        idle();

        // Reset holds off grants even with all requesters valid.
        for (int i = 0; i < 3; i++) set_req(i, 1, 0, 16'(i), 32'd0, 4'd0);
        step();
        step();
        rstn = 1;
        idle();
        step();

        // Single LS read of 0x0010.
        set_req(1, 1, 0, 16'h0010, 32'd0, 4'd0);
        step();
        idle();
        step();
        step();

        // All three contending: DBG holds the port, then LS, then IF.
        set_req(0, 1, 0, 16'h0100, 32'd0, 4'd0);
        set_req(1, 1, 0, 16'h0101, 32'd0, 4'd0);
        set_req(2, 1, 0, 16'h0102, 32'd0, 4'd0);
        step();
        step();
        step();
        set_req(0, 0, 0, 16'd0, 32'd0, 4'd0);
        step();
        set_req(1, 0, 0, 16'd0, 32'd0, 4'd0);
        step();
        idle();
        step();

        // LS partial write then IF reads the merged word.
        old_word = sram[16'h0020];
        set_req(1, 1, 1, 16'h0020, 32'h12345678, 4'b0011);
        step();
        set_req(1, 0, 0, 16'd0, 32'd0, 4'd0);
        set_req(2, 1, 0, 16'h0020, 32'd0, 4'd0);
        step();
        idle();
        step();
        chk("sram_merge", sram[16'h0020], {old_word[31:16], 16'h5678});

        // Fetch redirect kills the due IF response; the next IF access responds normally.
        set_req(2, 1, 0, 16'h0030, 32'd0, 4'd0);
        step();
        set_req(2, 1, 0, 16'h0031, 32'd0, 4'd0);
        bus.if_flush = 1;
        step();
        idle();
        step();

        // LS and IF both streaming: starvation behaviour.
        if_wins = 0;
        set_req(1, 1, 0, 16'h0040, 32'd0, 4'd0);
        set_req(2, 1, 0, 16'h0041, 32'd0, 4'd0);
        for (int c = 0; c < 15; c++) begin
            step();
            if (dut_g[2]) if_wins++;
        end
        chk("if_grant_count", if_wins, STARVE_ON ? 32'd3 : 32'd0);
        idle();
        step();

        // Reset the cycle after an LS grant drops its response.
        set_req(1, 1, 0, 16'h0050, 32'd0, 4'd0);
        step();
        rstn = 0;
        idle();
        step();
        step();
        rstn = 1;
        step();
        step();

        // Randomized traffic with hold-until-ready requesters.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!bus.req_valid[i] || exp_g[i])
                    set_req(i, $urandom_range(0, 99) < 60, (i == 2) ? 1'b0 : 1'($urandom),
                            16'($urandom_range(0, 15)), $urandom, 4'($urandom));
            end
            bus.if_flush = ($urandom_range(0, 3) == 0);
            step();
        end
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
